// File: rtl/systolic_pkg.sv
// Shared definitions for the 2x2 systolic feeder: controller states, feed length
// and the element positions used to pack matrices into flat buses.
package systolic_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FEED,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam int FEED_LEN = 3;

    // Element slot within a packed 2x2 matrix {M11,M10,M01,M00}
    localparam int IDX_00 = 0;
    localparam int IDX_01 = 1;
    localparam int IDX_10 = 2;
    localparam int IDX_11 = 3;

endpackage

// File: rtl/systolic_array_2x2.sv
// Output-stationary 2x2 systolic array: A flows right along rows, B flows down
// columns, each PE accumulates a*b modulo 2^(2*WIDTH).
module systolic_array_2x2 #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic [WIDTH-1:0]     a_data0,
    input  logic [WIDTH-1:0]     a_data1,
    input  logic [WIDTH-1:0]     b_data0,
    input  logic [WIDTH-1:0]     b_data1,
    output logic [2*WIDTH-1:0]   c00,
    output logic [2*WIDTH-1:0]   c01,
    output logic [2*WIDTH-1:0]   c10,
    output logic [2*WIDTH-1:0]   c11
);

    logic [WIDTH-1:0] a_r00, b_r00, a_r10, b_r01;

    function automatic logic [2*WIDTH-1:0] mac(input logic [2*WIDTH-1:0] acc,
                                               input logic [WIDTH-1:0]   a,
                                               input logic [WIDTH-1:0]   b);
        return acc + ({{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b});
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            c00 <= '0; c01 <= '0; c10 <= '0; c11 <= '0;
            a_r00 <= '0; b_r00 <= '0; a_r10 <= '0; b_r01 <= '0;
        end else if (clear) begin
            c00 <= '0; c01 <= '0; c10 <= '0; c11 <= '0;
            a_r00 <= '0; b_r00 <= '0; a_r10 <= '0; b_r01 <= '0;
        end else begin
            c00   <= mac(c00, a_data0, b_data0);
            c01   <= mac(c01, a_r00,   b_data1);
            c10   <= mac(c10, a_data1, b_r00);
            c11   <= mac(c11, a_r10,   b_r01);
            a_r00 <= a_data0;
            b_r00 <= b_data0;
            a_r10 <= a_data1;
            b_r01 <= b_data1;
        end
    end

endmodule

// File: rtl/systolic_feeder_2x2.sv
// Controller that loads one pair of 2x2 operands, streams them skewed into a
// 2x2 systolic array, waits for the array to drain and returns the product.
module systolic_feeder_2x2
    import systolic_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4*WIDTH-1:0]   a_mat,
    input  logic [4*WIDTH-1:0]   b_mat,
    output logic                 arr_clear,
    output logic [WIDTH-1:0]     arr_a0,
    output logic [WIDTH-1:0]     arr_a1,
    output logic [WIDTH-1:0]     arr_b0,
    output logic [WIDTH-1:0]     arr_b1,
    input  logic [2*WIDTH-1:0]   arr_c00,
    input  logic [2*WIDTH-1:0]   arr_c01,
    input  logic [2*WIDTH-1:0]   arr_c10,
    input  logic [2*WIDTH-1:0]   arr_c11,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [8*WIDTH-1:0]   c_mat,
    output logic                 busy
);

    localparam int CNT_MAX = (DRAIN_CYCLES > FEED_LEN) ? DRAIN_CYCLES : FEED_LEN;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] FEED_LAST  = CNT_W'(FEED_LEN - 1);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [4*WIDTH-1:0] a_q, b_q;
    logic               accept, capture, clr_nxt;
    logic [WIDTH-1:0]   a0_nxt, a1_nxt, b0_nxt, b1_nxt;

    function automatic logic [WIDTH-1:0] elem(input logic [4*WIDTH-1:0] m, input int idx);
        return m[idx*WIDTH +: WIDTH];
    endfunction

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign busy      = (state != S_IDLE);
    assign accept    = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        capture   = 1'b0;
        clr_nxt   = 1'b0;
        a0_nxt    = '0;
        a1_nxt    = '0;
        b0_nxt    = '0;
        b1_nxt    = '0;

        case (state)
            S_IDLE:  if (accept) state_nxt = S_CLEAR;
            S_CLEAR: begin
                state_nxt = S_FEED;
                cnt_nxt   = '0;
            end
            S_FEED: begin
                if (cnt == FEED_LAST) begin
                    state_nxt = S_DRAIN;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            S_DRAIN: begin
                if (cnt == DRAIN_LAST) begin
                    state_nxt = S_DONE;
                    cnt_nxt   = '0;
                    capture   = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            S_DONE:  if (out_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase

        // Array-facing values are chosen for the state being entered, so the
        // registered outputs line up with that state.
        if (state_nxt == S_CLEAR) begin
            clr_nxt = 1'b1;
        end else if (state_nxt == S_FEED) begin
            if (cnt_nxt == CNT_W'(0)) begin
                a0_nxt = elem(a_q, IDX_00);
                b0_nxt = elem(b_q, IDX_00);
            end else if (cnt_nxt == CNT_W'(1)) begin
                a0_nxt = elem(a_q, IDX_01);
                a1_nxt = elem(a_q, IDX_10);
                b0_nxt = elem(b_q, IDX_10);
                b1_nxt = elem(b_q, IDX_01);
            end else begin
                a1_nxt = elem(a_q, IDX_11);
                b1_nxt = elem(b_q, IDX_11);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            arr_clear <= 1'b0;
            arr_a0    <= '0;
            arr_a1    <= '0;
            arr_b0    <= '0;
            arr_b1    <= '0;
        end else begin
            arr_clear <= clr_nxt;
            arr_a0    <= a0_nxt;
            arr_a1    <= a1_nxt;
            arr_b0    <= b0_nxt;
            arr_b1    <= b1_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q   <= '0;
            b_q   <= '0;
            c_mat <= '0;
        end else begin
            if (accept) begin
                a_q <= a_mat;
                b_q <= b_mat;
            end
            if (capture) begin
                c_mat[IDX_00*2*WIDTH +: 2*WIDTH] <= arr_c00;
                c_mat[IDX_01*2*WIDTH +: 2*WIDTH] <= arr_c01;
                c_mat[IDX_10*2*WIDTH +: 2*WIDTH] <= arr_c10;
                c_mat[IDX_11*2*WIDTH +: 2*WIDTH] <= arr_c11;
            end
        end
    end

endmodule

// File: tb/tb_systolic_feeder_2x2.sv
// Bench: feeder driving a 2x2 systolic array, results compared to a plain
// matrix-multiply model under directed and randomized operands.
module tb_systolic_feeder_2x2;

    localparam int WIDTH = 8;
    localparam int DRAIN = 3;
    localparam int LAT   = 4 + DRAIN;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_valid, in_ready;
    logic [4*WIDTH-1:0]   a_mat, b_mat;
    logic                 arr_clear;
    logic [WIDTH-1:0]     arr_a0, arr_a1, arr_b0, arr_b1;
    logic [2*WIDTH-1:0]   arr_c00, arr_c01, arr_c10, arr_c11;
    logic                 out_valid, out_ready;
    logic [8*WIDTH-1:0]   c_mat;
    logic                 busy;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    systolic_feeder_2x2 #(.WIDTH(WIDTH), .DRAIN_CYCLES(DRAIN)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .a_mat(a_mat), .b_mat(b_mat),
        .arr_clear(arr_clear),
        .arr_a0(arr_a0), .arr_a1(arr_a1), .arr_b0(arr_b0), .arr_b1(arr_b1),
        .arr_c00(arr_c00), .arr_c01(arr_c01), .arr_c10(arr_c10), .arr_c11(arr_c11),
        .out_valid(out_valid), .out_ready(out_ready),
        .c_mat(c_mat), .busy(busy)
    );

    systolic_array_2x2 #(.WIDTH(WIDTH)) u_array (
        .clk(clk), .rst(rst), .clear(arr_clear),
        .a_data0(arr_a0), .a_data1(arr_a1), .b_data0(arr_b0), .b_data1(arr_b1),
        .c00(arr_c00), .c01(arr_c01), .c10(arr_c10), .c11(arr_c11)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // C = A*B with each element reduced modulo 2^16
    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] r;
        int unsigned s;
        r = '0;
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++) begin
                s = 0;
                for (int k = 0; k < 2; k++)
                    s += a[(2*i+k)*8 +: 8] * b[(2*k+j)*8 +: 8];
                r[(2*i+j)*16 +: 16] = s[15:0];
            end
        return r;
    endfunction

    function automatic logic [7:0] el(input logic [31:0] m, input int r, input int c);
        return m[(2*r+c)*8 +: 8];
    endfunction

    // Skewed feed word {a0,a1,b0,b1} for feed cycle n
    function automatic logic [31:0] sched(input logic [31:0] a, input logic [31:0] b, input int n);
        case (n)
            0:       return {el(a,0,0), 8'd0,      el(b,0,0), 8'd0};
            1:       return {el(a,0,1), el(a,1,0), el(b,1,0), el(b,0,1)};
            default: return {8'd0,      el(a,1,1), 8'd0,      el(b,1,1)};
        endcase
    endfunction

    task automatic do_txn(input logic [31:0] a, input logic [31:0] b, input int hold, input string tag);
        int          lat, clr_cnt, w;
        logic [31:0] rec [0:63];
        logic [63:0] exp_c;
        exp_c = ref_mul(a, b);
        w = 0;
        while (!in_ready && w < 50) begin tick(); w++; end
        check({tag, "_in_ready"}, in_ready, 1);
        a_mat = a; b_mat = b; in_valid = 1'b1;
        tick();
        in_valid = 1'b0; a_mat = $urandom; b_mat = $urandom;
        lat = 0;
        rec[0] = {arr_a0, arr_a1, arr_b0, arr_b1};
        clr_cnt = int'(arr_clear);
        while (!out_valid && lat < 60) begin
            tick();
            lat++;
            rec[lat] = {arr_a0, arr_a1, arr_b0, arr_b1};
            clr_cnt += int'(arr_clear);
        end
        check({tag, "_latency"}, lat, LAT);
        check({tag, "_clear_cycles"}, clr_cnt, 1);
        check({tag, "_clear_data"}, rec[0], 0);
        for (int n = 0; n < 3; n++)
            check($sformatf("%s_feed%0d", tag, n), rec[n+1], sched(a, b, n));
        check({tag, "_c_mat"}, c_mat, exp_c);
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'($urandom_range(0, 1));
            a_mat = $urandom; b_mat = $urandom;
            tick();
            check({tag, "_hold_valid"}, out_valid, 1);
            check({tag, "_hold_ready"}, in_ready, 0);
            check({tag, "_hold_c"}, c_mat, exp_c);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_after_valid"}, out_valid, 0);
        check({tag, "_after_ready"}, in_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] a1, b1, a2, b2;
        int          lat, ov_seen;

        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a_mat = '0; b_mat = '0;
        repeat (3) tick();
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_clear", arr_clear, 0);
        check("rst_arr_data", {arr_a0, arr_a1, arr_b0, arr_b1}, 0);
        check("rst_c_mat", c_mat, 0);
        rst = 1'b1;
        tick();

        do_txn({8'd4, 8'd3, 8'd2, 8'd1}, {8'd8, 8'd7, 8'd6, 8'd5}, 0, "mul1234");
        check("mul1234_const", c_mat, {16'd50, 16'd43, 16'd22, 16'd19});

        do_txn({8'd1, 8'd0, 8'd0, 8'd1}, {8'd6, 8'd7, 8'd8, 8'd9}, 0, "ident");
        check("ident_const", c_mat, {16'd6, 16'd7, 16'd8, 16'd9});

        do_txn(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "all255");
        check("all255_const", c_mat, {4{16'hFC02}});

        do_txn($urandom, $urandom, 10, "hold10");

        // Reset during FEED cycle 1
        a_mat = $urandom; b_mat = $urandom; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_clear", arr_clear, 0);
        check("mid_rst_arr_data", {arr_a0, arr_a1, arr_b0, arr_b1}, 0);
        check("mid_rst_c_mat", c_mat, 0);
        tick();
        rst = 1'b1;
        ov_seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            ov_seen += int'(out_valid);
        end
        check("mid_rst_no_result", ov_seen, 0);
        do_txn($urandom, $urandom, 1, "post_rst");

        // Back-to-back with both handshakes held high
        a1 = $urandom; b1 = $urandom; a2 = $urandom; b2 = $urandom;
        a_mat = a1; b_mat = b1; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        a_mat = a2; b_mat = b2;
        lat = 0;
        while (!out_valid && lat < 60) begin tick(); lat++; end
        check("b2b_lat1", lat, LAT);
        check("b2b_c1", c_mat, ref_mul(a1, b1));
        tick();
        check("b2b_idle_ready", in_ready, 1);
        check("b2b_idle_busy", busy, 0);
        tick();
        check("b2b_accept2_busy", busy, 1);
        check("b2b_accept2_ready", in_ready, 0);
        in_valid = 1'b0; a_mat = $urandom; b_mat = $urandom;
        lat = 0;
        while (!out_valid && lat < 60) begin tick(); lat++; end
        check("b2b_lat2", lat, LAT);
        check("b2b_c2", c_mat, ref_mul(a2, b2));
        tick();
        out_ready = 1'b0;
        check("b2b_done_valid", out_valid, 0);

        for (int t = 0; t < 15; t++)
            do_txn($urandom, $urandom, $urandom_range(0, 3), $sformatf("rand%0d", t));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
